mmio_timer: RTL

Memory-mapped timer peripheral that responds to the data-side bus driven by the single-cycle RISC-V core (`MemWrite`, `DataAdr`, `WriteData`). Stores hitting its address window update its registers on the clock edge. Loads inside the window return register contents combinationally on `ReadData`, so the core completes them in one cycle. It holds a prescaled up-counter with a compare match, overflow detection and a level interrupt. It sits beside the data memory, and the top level muxes `ReadData` using `Hit`.

---
 rtl/mmio_timer_pkg.sv | 20 ++
 rtl/timer_prescaler.sv | 29 ++
 rtl/mmio_timer.sv | 110 +++++++++++
 3 files changed

// File: rtl/mmio_timer_pkg.sv
// mmio_timer shared definitions.
// Register offsets, control/status bit positions and reset constants.
package mmio_timer_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_IE  = 2;
  localparam int ST_MATCH = 0;
  localparam int ST_OVF   = 1;

  // sliced down to the bus width by the timer
  localparam logic [63:0] COMPARE_RST = '1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for mmio_timer.
// Emits one tick every PRESCALE+1 enabled cycles.
module timer_prescaler #(
  parameter int width = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [width-1:0] PRESCALE,
  input  logic             clr,
  output logic             tick
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0] pre_cnt;

  assign tick = EN & (pre_cnt == PRESCALE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      pre_cnt <= '0;
    else if (clr | ~EN | tick)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + ONE;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare match,
// overflow flag and level interrupt.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int               width     = 32,
  parameter logic [width-1:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemWrite,
  input  logic [width-1:0] DataAdr,
  input  logic [width-1:0] WriteData,
  output logic [width-1:0] ReadData,
  output logic             Hit,
  output logic             IRQ
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  logic [2:0]       ctrl;
  logic [width-1:0] prescale;
  logic [width-1:0] count;
  logic [width-1:0] compare;
  logic [1:0]       status;

  logic [2:0] sel;
  logic       wr;
  logic       s_ctrl, s_pre, s_cnt, s_cmp, s_st;
  logic       en_chg, clr, tick;
  logic       is_match, is_max;
  logic       set_match, set_ovf;
  logic [1:0] w1c;
  logic [width-1:0] rd;
  logic       unused_adr;

  assign sel = DataAdr[4:2];
  assign Hit = DataAdr[width-1:5] == BASE_ADDR[width-1:5];
  assign wr  = MemWrite & Hit;
  assign unused_adr = ^DataAdr[1:0];

  assign s_ctrl = sel == OFF_CTRL;
  assign s_pre  = sel == OFF_PRESCALE;
  assign s_cnt  = sel == OFF_COUNT;
  assign s_cmp  = sel == OFF_COMPARE;
  assign s_st   = sel == OFF_STATUS;

  assign en_chg = wr & s_ctrl
                & (WriteData[CTRL_EN] != ctrl[CTRL_EN]);
  assign clr    = (wr & s_cnt) | (wr & s_pre) | en_chg;

  timer_prescaler #(.width(width)) u_pre (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (ctrl[CTRL_EN]),
    .PRESCALE (prescale),
    .clr      (clr),
    .tick     (tick)
  );

  assign is_match  = count == compare;
  assign is_max    = &count;
  assign set_match = tick & is_match;
  assign set_ovf   = tick & ~is_match & is_max;
  assign w1c       = {2{wr & s_st}} & WriteData[1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl     <= '0;
      prescale <= '0;
      count    <= '0;
      compare  <= COMPARE_RST[width-1:0];
      status   <= '0;
    end else begin
      if (wr & s_ctrl) ctrl     <= WriteData[2:0];
      if (wr & s_pre)  prescale <= WriteData;
      if (wr & s_cmp)  compare  <= WriteData;
      // a bus write to COUNT beats the tick
      if (wr & s_cnt)
        count <= WriteData;
      else if (tick) begin
        if ((is_match & ctrl[CTRL_AR]) | (~is_match & is_max))
          count <= '0;
        else
          count <= count + ONE;
      end
      // hardware set wins over a same-cycle clear
      status <= (status & ~w1c) | {set_ovf, set_match};
    end
  end

  assign IRQ = ctrl[CTRL_IE] & (|status);

  always_comb begin
    rd = '0;
    if (Hit) begin
      unique case (1'b1)
        s_ctrl:  rd[2:0] = ctrl;
        s_pre:   rd = prescale;
        s_cnt:   rd = count;
        s_cmp:   rd = compare;
        s_st:    rd[1:0] = status;
        default: rd = '0;
      endcase
    end
  end

  assign ReadData = rd;

endmodule
